// File: rtl/counter_sched_pkg.sv
// rtl/counter_sched_pkg.sv - shared types and constants for the counter job scheduler
// Purpose: FSM state encoding, direction encoding and default sizes used by
//          counter_job_scheduler and its testbench.
// Ports:   none (package).
package counter_sched_pkg;

  localparam int DEFAULT_N       = 8;
  localparam int DEFAULT_NUM_REQ = 4;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first asserted request at or after ptr, wrapping.
// Ports:
//   req  in  NUM_REQ  request vector
//   ptr  in  IW       index with highest priority this round
//   gnt  out NUM_REQ  one-hot winner (zero when nothing requested)
//   idx  out IW       encoded winner
//   any  out 1        at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [IW:0]   sum;
  logic [IW-1:0] c;

  // Walk from lowest to highest priority so the last hit (ptr itself) wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    c   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end
      c = sum[IW-1:0];
      if (req[c]) begin
        gnt    = '0;
        gnt[c] = 1'b1;
        idx    = c;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_job_scheduler.sv
// rtl/counter_job_scheduler.sv - round-robin scheduler sharing one up/down counter
// Purpose: grants the counter to one requester at a time, loads its preset,
//          runs it in the requested direction until ctr_expired, then pulses done.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req/req_dir/req_value    per-requester job request, direction, preset
//   hold                     global pause request (honoured only while running)
//   grant, done, busy        requester-side status
//   new_cntr_preset(_value)  preset load strobe and value to the counter
//   enable_cnt_up/dn         count enables to the counter
//   pause_counting           pause to the counter
//   counter, ctr_expired     counter value (checking only) and terminal flag
module counter_job_scheduler
  import counter_sched_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_dir,
  input  logic [NUM_REQ*N-1:0] req_value,
  input  logic                 hold,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic                 new_cntr_preset,
  output logic [N-1:0]         new_cntr_preset_value,
  output logic                 enable_cnt_up,
  output logic                 enable_cnt_dn,
  output logic                 pause_counting,
  input  logic [N-1:0]         counter,
  input  logic                 ctr_expired
);

  localparam int IW = $clog2(NUM_REQ);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        ptr_next;
  logic                 dir_q;
  logic [N-1:0]         value_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // The owner just served drops to lowest priority next round.
  assign ptr_next = (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + IW'(1);

  always_comb begin
    state_d         = state_q;
    new_cntr_preset = 1'b0;
    enable_cnt_up   = 1'b0;
    enable_cnt_dn   = 1'b0;
    pause_counting  = 1'b0;
    done            = '0;
    case (state_q)
      IDLE: begin
        if (arb_any) state_d = LOAD;
      end
      LOAD: begin
        new_cntr_preset = 1'b1;
        state_d         = SETTLE;
      end
      SETTLE: begin
        // One idle cycle so ctr_expired reflects the freshly loaded preset.
        state_d = RUN;
      end
      RUN: begin
        enable_cnt_up  = (dir_q == DIR_UP) & ~ctr_expired;
        enable_cnt_dn  = (dir_q == DIR_DN) & ~ctr_expired;
        pause_counting = hold;
        // Expiry is checked first so a request drop on the same cycle still completes.
        if (ctr_expired) begin
          state_d = DONE;
        end else if (!req[idx_q]) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        done    = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      dir_q   <= 1'b0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q <= arb_gnt;
            idx_q   <= arb_idx;
            dir_q   <= req_dir[arb_idx];
            value_q <= req_value[int'(arb_idx)*N +: N];
          end
        end
        RUN: begin
          if (state_d == IDLE) begin
            grant_q <= '0;
            ptr_q   <= ptr_next;
          end
        end
        DONE: begin
          grant_q <= '0;
          ptr_q   <= ptr_next;
        end
        default: ;
      endcase
    end
  end

  assign grant                 = grant_q;
  assign busy                  = (state_q != IDLE);
  assign new_cntr_preset_value = value_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(grant_q));
      assert (!(enable_cnt_up && enable_cnt_dn));
      assert (!(new_cntr_preset && (enable_cnt_up || enable_cnt_dn)));
      if (state_q == RUN && ctr_expired) begin
        assert (counter == {N{dir_q}});
      end
    end
  end

endmodule

// File: tb/tb_counter_job_scheduler.sv
// tb/tb_counter_job_scheduler.sv - scoreboard bench for counter_job_scheduler
module tb_counter_job_scheduler;
  import counter_sched_pkg::*;

  localparam int N  = 8;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req, req_dir;
  logic [NR*N-1:0] req_value;
  logic            hold;
  logic [NR-1:0]   grant, done;
  logic            busy, new_cntr_preset;
  logic [N-1:0]    new_cntr_preset_value;
  logic            enable_cnt_up, enable_cnt_dn, pause_counting;
  logic [N-1:0]    counter;
  logic            ctr_expired;

  always #5 clk = ~clk;

  counter_job_scheduler #(.N(N), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dir(req_dir), .req_value(req_value),
    .hold(hold), .grant(grant), .done(done), .busy(busy),
    .new_cntr_preset(new_cntr_preset), .new_cntr_preset_value(new_cntr_preset_value),
    .enable_cnt_up(enable_cnt_up), .enable_cnt_dn(enable_cnt_dn),
    .pause_counting(pause_counting), .counter(counter), .ctr_expired(ctr_expired)
  );

  typedef struct {
    bit is_done;
    int idx;
    int cyc;
    int val;
    bit dir;
    int ens;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  model_ptr = 0;
  int  last_done = 0;
  int  job_val [NR];
  bit  job_dir [NR];
  int  exp_e   [NR];
  int  drop_at [NR];
  int  stop_cycle = -1;
  bit  sticky_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int oh2idx(input logic [NR-1:0] v);
    int r;
    r = 0;
    for (int k = 0; k < NR; k++) if (v[k]) r = k;
    return r;
  endfunction

  // Behavioural counter: preset load, pause, up/down, terminal flag per job direction.
  logic [N-1:0] cnt  = '0;
  bit           cdir = 1'b0;
  always @(posedge clk) begin
    if (new_cntr_preset) begin
      cnt  <= new_cntr_preset_value;
      cdir <= job_dir[oh2idx(grant)];
    end else if (!pause_counting) begin
      if (enable_cnt_up) cnt <= cnt + 1'b1;
      else if (enable_cnt_dn) cnt <= cnt - 1'b1;
    end
  end
  assign counter     = cnt;
  assign ctr_expired = cdir ? (cnt == '1) : (cnt == '0);

  task automatic chk(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got=%0d required=%0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Job-level timing model: one job at a time, round-robin from the pointer;
  // a job granted at G needs dist (+pause) counting cycles starting at G+2,
  // its done is one cycle after expiry, and the next grant two cycles after done.
  function automatic void schedule(input logic [NR-1:0] mask_in, input int t_idle,
                                   input int njobs, input bit sticky, input int extra);
    logic [NR-1:0] mask;
    int t, n, w, d, e;
    mask = mask_in;
    t = t_idle;
    n = 0;
    while (mask != 0 && n < njobs) begin
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && mask[(model_ptr + k) % NR]) w = (model_ptr + k) % NR;
      d = job_dir[w] ? (255 - job_val[w]) : job_val[w];
      if (n == 0) d = d + extra;
      e = t + 1 + 2 + d;
      exp_q.push_back('{1'b0, w, t + 1, job_val[w], job_dir[w], 0});
      exp_q.push_back('{1'b1, w, e + 1, job_val[w], job_dir[w], d});
      exp_e[w]  = e;
      last_done = e + 1;
      model_ptr = (w + 1) % NR;
      if (!sticky) mask[w] = 1'b0;
      t = e + 2;
      n++;
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (!sticky_mode && (done[i] || cyc == drop_at[i])) req[i] = 1'b0;
      if (cyc == stop_cycle) req[i] = 1'b0;
      if (!sticky_mode && grant[i]) begin
        req_value[i*N +: N] = N'($urandom);
        req_dir[i]          = 1'($urandom);
      end
    end
  endtask

  task automatic post(input int i, input int v, input bit d);
    job_val[i]          = v;
    job_dir[i]          = d;
    req_value[i*N +: N] = N'(v);
    req_dir[i]          = d;
    req[i]              = 1'b1;
  endtask

  task automatic drain(input int limit);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < limit) begin
      tick();
      g++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_preset"}, new_cntr_preset, 0);
    chk({tag, "_value"}, new_cntr_preset_value, 0);
    chk({tag, "_en_up"}, enable_cnt_up, 0);
    chk({tag, "_en_dn"}, enable_cnt_dn, 0);
    chk({tag, "_pause"}, pause_counting, 0);
  endtask

  task automatic random_batch();
    logic [NR-1:0] mask;
    int r;
    bit d;
    tick();
    mask = NR'($urandom_range(1, 15));
    for (int i = 0; i < NR; i++) begin
      drop_at[i] = -1;
      if (mask[i]) begin
        d = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 12);
        post(i, d ? 255 - r : r, d);
      end
    end
    schedule(mask, cyc, NR, 1'b0, 0);
    for (int i = 0; i < NR; i++)
      if (mask[i] && $urandom_range(0, 3) == 0) drop_at[i] = exp_e[i];
    drain(3000);
  endtask

  // Monitor: invariants every cycle, and scoreboard pops on grant rise / done pulse.
  logic [NR-1:0] prev_grant = '0;
  int            en_cnt = 0;
  bit            cur_dir = 1'b0;

  task automatic take_event(input bit is_done, input int idx);
    ev_t ev;
    bit  ok;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: done=%0b idx=%0d cycle=%0d required=none", is_done, idx, cyc);
      return;
    end
    ev = exp_q.pop_front();
    ok = (ev.is_done == is_done) && (ev.idx == idx) && (ev.cyc == cyc);
    if (!is_done) ok = ok && (int'(new_cntr_preset_value) == ev.val);
    else ok = ok && (en_cnt == ev.ens) && (done == grant) && $onehot(done);
    if (!ok) begin
      bad++;
      $display("FAIL event: got done=%0b idx=%0d cyc=%0d value=%0d ens=%0d required done=%0b idx=%0d cyc=%0d value=%0d ens=%0d",
               is_done, idx, cyc, new_cntr_preset_value, en_cnt, ev.is_done, ev.idx, ev.cyc, ev.val, ev.ens);
    end
    if (!is_done) cur_dir = ev.dir;
  endtask

  always begin
    @(negedge clk);
    #1;
    chk("grant_onehot0", int'($onehot0(grant)), 1);
    chk("en_exclusive", int'(enable_cnt_up & enable_cnt_dn), 0);
    chk("preset_vs_enable", int'(new_cntr_preset & (enable_cnt_up | enable_cnt_dn)), 0);
    chk("busy_vs_grant", int'(busy), int'(|grant));
    chk("preset_on_grant_rise", int'(new_cntr_preset), int'(grant != 0 && prev_grant == 0));
    if (grant != 0 && prev_grant == 0) begin
      en_cnt = 0;
      take_event(1'b0, oh2idx(grant));
    end
    if (enable_cnt_up | enable_cnt_dn) begin
      en_cnt++;
      chk("en_direction", int'(enable_cnt_up), int'(cur_dir));
    end
    if (done != 0) take_event(1'b1, oh2idx(done));
    prev_grant = grant;
  end

  initial begin
    int t0, perr;
    rst = 1'b1; req = '0; req_dir = '0; req_value = '0; hold = 1'b0;
    for (int i = 0; i < NR; i++) drop_at[i] = -1;
    repeat (3) tick();
    #1 check_quiet("reset");
    tick();
    rst = 1'b0;

    // Continuous 1111: grants 0,1,2,3,0
    tick();
    sticky_mode = 1'b1;
    post(0, 3, 1'b0); post(1, 5, 1'b0); post(2, 2, 1'b0); post(3, 7, 1'b0);
    schedule(4'hF, cyc, 5, 1'b1, 0);
    stop_cycle = last_done;
    drain(2000);
    sticky_mode = 1'b0;
    stop_cycle  = -1;

    // Single job, value 3 down
    tick();
    post(0, 3, 1'b0);
    schedule(4'b0001, cyc, 1, 1'b0, 0);
    drain(500);

    // Zero-length job
    tick();
    post(0, 0, 1'b0);
    schedule(4'b0001, cyc, 1, 1'b0, 0);
    drain(500);

    // Hold: ignored in IDLE, mirrored in RUN, delays done by its length
    tick();
    hold = 1'b1;
    #1 chk("pause_idle", pause_counting, 0);
    tick();
    hold = 1'b0;
    post(2, 250, 1'b1);
    t0 = cyc;
    schedule(4'b0100, t0, 1, 1'b0, 20);
    repeat (3) tick();
    hold = 1'b1;
    perr = 0;
    #1 if (pause_counting !== 1'b1) perr++;
    repeat (19) begin
      tick();
      #1 if (pause_counting !== 1'b1) perr++;
    end
    tick();
    hold = 1'b0;
    #1 chk("pause_mirrors_hold", perr, 0);
    chk("pause_release", pause_counting, 0);
    drain(500);

    // Abort: requester 1 drops mid-RUN, 0 and 3 waiting
    tick();
    post(1, 200, 1'b0);
    t0 = cyc;
    exp_q.push_back('{1'b0, 1, t0 + 1, 200, 1'b0, 0});
    repeat (6) tick();
    req[1] = 1'b0;
    post(0, 4, 1'b0);
    post(3, 250, 1'b1);
    model_ptr = 2;
    schedule(4'b1001, t0 + 7, NR, 1'b0, 0);
    tick();
    #1 chk("abort_en_up", enable_cnt_up, 0);
    chk("abort_en_dn", enable_cnt_dn, 0);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", done, 0);
    drain(1000);

    for (int b = 0; b < 8; b++) random_batch();

    // Reset in the middle of RUN
    tick();
    post(1, 100, 1'b0);
    t0 = cyc;
    exp_q.push_back('{1'b0, 1, t0 + 1, 100, 1'b0, 0});
    repeat (8) tick();
    rst = 1'b1;
    req = '0;
    exp_q.delete();
    tick();
    #1 check_quiet("midrun_reset");
    tick();
    rst = 1'b0;
    post(2, 5, 1'b0);
    model_ptr = 0;
    schedule(4'b0100, cyc, 1, 1'b0, 0);
    drain(500);

    for (int b = 0; b < 4; b++) random_batch();

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_job_scheduler.md
Name: counter_job_scheduler

Overview:
- Shares one multifunction up/down counter (preset, pause, ctr_expired) among NUM_REQ requesters.
- Each requester posts a timing job: preset value plus direction.
- Scheduler arbitrates round-robin, loads the preset, runs the counter in the requested direction until ctr_expired, then returns a done pulse to the owner.
- Sits between requester logic and the counter instance and drives all counter control inputs.

Parameters:
- N, 8, counter/preset width; must equal the counter's N.
- NUM_REQ, 4, number of requesters, 2..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester job request level; must stay high until done or abort.
- req_dir  in  NUM_REQ  per-requester direction: 1 = up, 0 = down.
- req_value  in  NUM_REQ*N  per-requester preset; slice i is bits [i*N +: N].
- hold  in  1  global pause request.
- grant  out  NUM_REQ  one-hot owner of the counter; all-zero when idle.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- busy  out  1  high in any state other than IDLE.
- new_cntr_preset  out  1  preset-load strobe to the counter.
- new_cntr_preset_value  out  N  latched preset value of the granted job.
- enable_cnt_up  out  1  count-up enable to the counter.
- enable_cnt_dn  out  1  count-down enable to the counter.
- pause_counting  out  1  pause to the counter.
- counter  in  N  counter value, used for debug/assertions only.
- ctr_expired  in  1  counter terminal flag: counter == 0 when counting down, all-ones when counting up.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state = IDLE; grant, done, busy, new_cntr_preset, new_cntr_preset_value, enable_cnt_up, enable_cnt_dn, pause_counting = 0; round-robin pointer = 0.
- Reset asserted mid-job: the next edge forces all of the above; no done pulse is issued.
- FSM states: IDLE, LOAD, SETTLE, RUN, DONE.
- IDLE:
  - If any req bit is high, pick the winner g by round-robin starting at the pointer; next state LOAD.
  - grant, dir_q and value_q are registered on that same edge.
- LOAD, 1 cycle: new_cntr_preset = 1; new_cntr_preset_value = value_q; next state SETTLE.
- SETTLE, 1 cycle: all enables = 0, so the counter output and ctr_expired settle to the preset; next state RUN.
- RUN:
  - enable_cnt_up = dir_q & ~ctr_expired; enable_cnt_dn = ~dir_q & ~ctr_expired. These are combinational.
  - pause_counting = hold. It is 0 in every other state, and enables stay high while paused.
  - If ctr_expired: next state DONE.
  - Else if req[g] = 0: abort to IDLE, pointer = g+1, no done pulse.
- DONE, 1 cycle: done[g] = 1; enables = 0; grant cleared on exit; pointer = (g+1) mod NUM_REQ; next state IDLE.
- Latency, req high in IDLE at cycle t:
  - grant at t+1, together with new_cntr_preset.
  - First enable at t+3.
  - ctr_expired seen at cycle e gives done at e+1 and IDLE at e+2.
  - A waiting requester gets its grant at e+3.
- Zero-length job (preset already terminal, e.g. value 0 counting down): ctr_expired is high on entry to RUN, enables never assert, DONE follows next cycle.
- Simultaneous ctr_expired and req[g] drop: expiry wins and done is issued.
- hold and ctr_expired together: expiry wins.
- req_value/req_dir changes after grant are ignored because they are latched.
- A non-granted requester's req may rise or fall freely.
- Invariants: grant is one-hot or zero; enable_cnt_up & enable_cnt_dn is never 1; new_cntr_preset is never high together with an enable.

Decomposition:
- Package counter_sched_pkg:
  - state enum {IDLE, LOAD, SETTLE, RUN, DONE};
  - DIR_UP = 1'b1, DIR_DN = 1'b0;
  - default N and NUM_REQ constants.
- Sub-module rr_arbiter #(NUM_REQ): combinational.
  - Inputs: req, ptr.
  - Outputs: one-hot gnt, encoded idx, any.
- Top holds the FSM, the job latches and the pointer register.

Test Plan:
- Reset, then req = 4'b0001, value0 = 8'd3, down → new_cntr_preset high one cycle with value 3; enable_cnt_dn high until ctr_expired; done[0] pulses once; busy falls 2 cycles after expiry.
- req = 4'b1111 held continuously with distinct values → grants issued in order 0,1,2,3,0; each done on the matching bit; grant is never multi-hot.
- Job 2 with value 8'd250, up, hold pulsed 20 cycles mid-RUN → pause_counting mirrors hold only in RUN; done[2] is delayed by exactly 20 cycles versus the no-hold run.
- Job 1 running, req[1] dropped mid-RUN → enables drop next cycle; no done; IDLE; next grant goes to the lowest waiting index ≥ 2 (wrapping).
- Job value 8'd0, down → no enable cycle; done[0] 3 cycles after the LOAD cycle.
- rst asserted during RUN → all outputs 0 on the next edge, pointer 0; a re-issued req = 4'b0100 is granted at t+1 after reset release.
